// File: rtl/enable_counter.sv
// Free-running up-counter with clock enable, terminal-count decode and wrap pulse.
// Either wraps to zero or saturates at MAX_VALUE, depending on SATURATE.
module enable_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("enable_counter: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MAX_VALUE >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("enable_counter: MAX_VALUE=%0d does not fit in WIDTH=%0d", MAX_VALUE, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);

  logic             at_max;
  logic             in_range;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  assign at_max = (count == MAX_C);
  assign tc     = at_max;

  // With an all-ones terminal value every count is in range; skip the compare.
  if (MAX_C == '1) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (count <= MAX_C);
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (enable) begin
      if (at_max) begin
        if (!SATURATE) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else if (in_range) begin
        count_nxt = count + WIDTH'(1);
      end else begin
        count_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_enable_counter.sv
// Directed bench for enable_counter: wrap, saturate, reset priority and
// degenerate terminal-value configurations with hand-computed expectations.
module tb_enable_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // A: WIDTH=8 default MAX, wrap mode
  logic       rst_a, en_a, tc_a, wrap_a;
  logic [7:0] cnt_a;
  enable_counter #(.WIDTH(8)) u_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .count(cnt_a), .tc(tc_a), .wrap(wrap_a)
  );

  // B: WIDTH=4 default MAX
  logic       rst_b, en_b, tc_b, wrap_b;
  logic [3:0] cnt_b;
  enable_counter #(.WIDTH(4)) u_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .count(cnt_b), .tc(tc_b), .wrap(wrap_b)
  );

  // C: WIDTH=8, MAX=9, wrap mode
  logic       rst_c, en_c, tc_c, wrap_c;
  logic [7:0] cnt_c;
  enable_counter #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b0)) u_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .count(cnt_c), .tc(tc_c), .wrap(wrap_c)
  );

  // D: WIDTH=8, MAX=9, saturate mode
  logic       rst_d, en_d, tc_d, wrap_d;
  logic [7:0] cnt_d;
  enable_counter #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b1)) u_d (
    .clk(clk), .reset(rst_d), .enable(en_d), .count(cnt_d), .tc(tc_d), .wrap(wrap_d)
  );

  // E: WIDTH=4, MAX=0, wrap mode
  logic       rst_e, en_e, tc_e, wrap_e;
  logic [3:0] cnt_e;
  enable_counter #(.WIDTH(4), .MAX_VALUE(0), .SATURATE(1'b0)) u_e (
    .clk(clk), .reset(rst_e), .enable(en_e), .count(cnt_e), .tc(tc_e), .wrap(wrap_e)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    {rst_a, rst_b, rst_c, rst_d, rst_e} = '1;
    {en_a, en_b, en_c, en_d, en_e}       = '0;
    step();

    // A: reset with enable high, held 5 cycles
    en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_rst_count", 32'(cnt_a), 32'd0);
      chk("a_rst_wrap", 32'(wrap_a), 32'd0);
      chk("a_rst_tc", 32'(tc_a), 32'd0);
    end
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("a_count10", 32'(cnt_a), 32'd10);
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("a_hold", 32'(cnt_a), 32'd10);
    end
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("a_count13", 32'(cnt_a), 32'd13);
    en_a = 1'b0;

    // B: natural 4-bit rollover
    step();
    chk("b_rst_count", 32'(cnt_b), 32'd0);
    rst_b = 1'b0;
    en_b  = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("b_count", 32'(cnt_b), 32'(k));
      chk("b_tc", 32'(tc_b), (k == 15) ? 32'd1 : 32'd0);
      chk("b_wrap_lo", 32'(wrap_b), 32'd0);
    end
    step();
    chk("b_roll_count", 32'(cnt_b), 32'd0);
    chk("b_roll_wrap", 32'(wrap_b), 32'd1);
    chk("b_roll_tc", 32'(tc_b), 32'd0);
    step();
    chk("b_after_count", 32'(cnt_b), 32'd1);
    chk("b_after_wrap", 32'(wrap_b), 32'd0);
    en_b = 1'b0;

    // C: modulo-10 with enable held
    rst_c = 1'b0;
    en_c  = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("c_count", 32'(cnt_c), 32'(k % 10));
      chk("c_wrap", 32'(wrap_c), (k % 10 == 0) ? 32'd1 : 32'd0);
    end
    // C: enable toggling, enabled on odd edges only
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      en_c = (k % 2 == 1);
      step();
      chk("c_tog_count", 32'(cnt_c), 32'(((k + 1) / 2) % 10));
      chk("c_tog_wrap", 32'(wrap_c), (k == 19 || k == 39) ? 32'd1 : 32'd0);
    end
    // C: reset on the edge that would wrap
    rst_c = 1'b1;
    en_c  = 1'b1;
    step();
    rst_c = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("c_pre_count", 32'(cnt_c), 32'd9);
    chk("c_pre_tc", 32'(tc_c), 32'd1);
    rst_c = 1'b1;
    step();
    chk("c_rstwin_count", 32'(cnt_c), 32'd0);
    chk("c_rstwin_wrap", 32'(wrap_c), 32'd0);
    chk("c_rstwin_tc", 32'(tc_c), 32'd0);
    step();
    chk("c_rstwin_wrap2", 32'(wrap_c), 32'd0);
    en_c = 1'b0;

    // D: saturate at 9
    rst_d = 1'b0;
    en_d  = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("d_count", 32'(cnt_d), (k >= 9) ? 32'd9 : 32'(k));
      chk("d_tc", 32'(tc_d), (k >= 9) ? 32'd1 : 32'd0);
      chk("d_wrap", 32'(wrap_d), 32'd0);
    end
    rst_d = 1'b1;
    step();
    chk("d_rst_count", 32'(cnt_d), 32'd0);
    chk("d_rst_tc", 32'(tc_d), 32'd0);
    en_d = 1'b0;

    // E: MAX_VALUE=0
    chk("e_rst_tc", 32'(tc_e), 32'd1);
    rst_e = 1'b0;
    en_e  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      en_e = (k != 3);
      step();
      chk("e_count", 32'(cnt_e), 32'd0);
      chk("e_tc", 32'(tc_e), 32'd1);
      chk("e_wrap", 32'(wrap_e), (k != 3) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enable_counter.md
Name: enable_counter

Overview:
- Free-running up-counter with a clock enable and a synchronous active-high reset.
- It is the generic time base used by the buzzer/tone logic (one-second LED timer, tempo counter, note half-period counter).
- Counts clock cycles while enabled. Wraps or saturates at a configurable terminal value.
- Flags the terminal value and each wrap event.

Parameters:
- WIDTH, 8: bit width of count; legal range 1..32.
- MAX_VALUE, 2**WIDTH-1: terminal count value; legal range 0..2**WIDTH-1.
- SATURATE, 0: 0 = wrap to 0 after MAX_VALUE; 1 = hold at MAX_VALUE.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk only.
- reset  input  1  synchronous, active-high reset; sampled on posedge clk.
- enable  input  1  count enable; active-high.
- count  output  WIDTH  current count value (registered).
- tc  output  1  terminal count: high when count == MAX_VALUE (combinational decode of the count register).
- wrap  output  1  registered one-cycle pulse, high on the cycle after count wrapped MAX_VALUE->0.

Behaviour:
- Clocking and reset: one clock domain, no asynchronous paths. Reset is synchronous and active-high.
- Priority at each posedge clk: reset, then enable, then hold.
- reset=1:
  - count <= 0, wrap <= 0, regardless of enable.
  - tc then reflects count==MAX_VALUE, i.e. tc=1 after reset only when MAX_VALUE==0.
- reset=0, enable=0: count and tc hold their values; wrap <= 0.
- reset=0, enable=1, count != MAX_VALUE: count <= count+1; wrap <= 0.
- reset=0, enable=1, count == MAX_VALUE:
  - SATURATE=0: count <= 0, wrap <= 1.
  - SATURATE=1: count holds at MAX_VALUE, wrap <= 0.
- Latency: enable asserted on cycle N produces an incremented count visible after posedge N. Counting is one increment per enabled clock; there is no prescaler.
- Arithmetic:
  - Increment is unsigned, WIDTH bits.
  - With MAX_VALUE = 2**WIDTH-1, wrap is the natural modulo-2**WIDTH rollover.
  - The comparison against MAX_VALUE uses the full WIDTH bits.
- Out-of-range count: if count > MAX_VALUE (only possible after a parameter mismatch; not reachable in normal operation), the next enabled clock forces count <= 0 and wrap <= 0.
- Degenerate MAX_VALUE=0: count stays 0, tc stays 1. With SATURATE=0, wrap pulses on every enabled clock.
- Enable toggling: gaps in enable simply pause counting. No count is lost or duplicated.
- Reset mid-count: count returns to 0 on that edge. A wrap that would have happened on the same edge is suppressed (wrap=0).
- Power-up: no initial values are relied on. Outputs are defined only after the first reset edge.
- Synthesis and lint:
  - Pure synchronous RTL; no latches, no tri-states.
  - Parameter legality is checked at elaboration: error if MAX_VALUE >= 2**WIDTH or WIDTH == 0.

Test Plan:
- Reset with enable=1, WIDTH=8 -> count=0, wrap=0, tc=0 on the cycle after reset. Holding reset for 5 cycles keeps count=0.
- Release reset, enable=1 for 10 cycles -> count=10. Drop enable for 4 cycles -> count stays 10. Re-enable 3 cycles -> count=13.
- WIDTH=4, default MAX, enable held -> count 0..15; tc=1 exactly while count=15; next edge count=0 and wrap=1 for one cycle; wrap=0 afterwards.
- WIDTH=8, MAX_VALUE=9, SATURATE=0 -> count cycles 0..9; wrap pulses every 10 enabled clocks. With enable toggling every other cycle, wrap pulses every 20 clocks.
- WIDTH=8, MAX_VALUE=9, SATURATE=1 -> count reaches 9 and stays; tc stays 1; wrap never asserts. Reset returns count to 0.
- Assert reset on the same edge where count==MAX_VALUE with enable=1 (SATURATE=0) -> count=0, wrap=0 (reset wins, no wrap pulse).
